fp_addsub_pipe: RTL and testbench

Pipelined, parametrised IEEE-754-style floating-point adder/subtractor with a valid/ready stream interface. It accepts one operation per cycle, computes `a + b` or `a - b`, and applies round-to-nearest-even. Inputs and results use flush-to-zero for subnormals, and zero, infinity and NaN are handled explicitly. It sits between operand producers and result consumers in the arithmetic datapath and replaces the single-cycle combinational adder wherever throughput, backpressure or correct rounding is needed.

---
 rtl/fp_addsub_pipe.sv | 253 +++++++++++++++++++++++++
 tb/tb_fp_addsub_pipe.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_addsub_pipe.sv
// Three-stage IEEE-754-style adder/subtractor: unpack/align, add/LZC, normalise/round/pack.
// One global advance enable moves every stage together, so a stalled output freezes the whole pipe.
module fp_addsub_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  input  logic                 op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] sum,
  output logic                 overflow,
  output logic                 underflow,
  output logic                 invalid
);
  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int MW  = MAN_W + 4;          // hidden + fraction + guard/round/sticky
  localparam int SW  = MAN_W + 5;          // MW plus carry-out
  localparam int EW  = EXP_W + 2;          // signed exponent with headroom both ways
  localparam int LZW = $clog2(MW + 1);
  localparam logic [EXP_W-1:0]     EXP_ONES = '1;
  localparam logic [EXP_W-1:0]     SH_MAX   = EXP_W'(MAN_W + 3);
  localparam logic signed [EW-1:0] EXP_INF  = EW'(2**EXP_W - 1);
  localparam logic signed [EW-1:0] ONE_S    = EW'(1);
  localparam logic signed [EW-1:0] ZERO_S   = '0;
  localparam logic [W-1:0]         QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // ---------------- S1: unpack / classify / align ----------------
  logic             s1_sa, s1_sb, s1_a_big;
  logic             nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
  logic [EXP_W-1:0] s1_ea, s1_eb, s1_diff, s1_sh;
  logic [MAN_W-1:0] s1_fa, s1_fb;
  logic [MW-1:0]    s1_ma, s1_mb, s1_msml, s1_mask;

  logic             v1_d, v1_q, sign1_d, sign1_q, sub1_d, sub1_q;
  logic             spec1_d, spec1_q, inv1_d, inv1_q;
  logic [EXP_W-1:0] exp1_d, exp1_q;
  logic [MW-1:0]    mbig1_d, mbig1_q, msml1_d, msml1_q;
  logic [W-1:0]     sw1_d, sw1_q;

  // NOTE: every always_comb output gets a default before any branch, so no path can infer a latch.
  always_comb begin
    s1_sa   = a[W-1];
    s1_sb   = b[W-1] ^ op;
    s1_ea   = a[W-2:MAN_W];
    s1_eb   = b[W-2:MAN_W];
    s1_fa   = (s1_ea == '0) ? '0 : a[MAN_W-1:0];
    s1_fb   = (s1_eb == '0) ? '0 : b[MAN_W-1:0];
    s1_ma   = {s1_ea != '0, s1_fa, 3'b000};
    s1_mb   = {s1_eb != '0, s1_fb, 3'b000};
    nan_a   = (s1_ea == EXP_ONES) && (a[MAN_W-1:0] != '0);
    nan_b   = (s1_eb == EXP_ONES) && (b[MAN_W-1:0] != '0);
    inf_a   = (s1_ea == EXP_ONES) && (a[MAN_W-1:0] == '0);
    inf_b   = (s1_eb == EXP_ONES) && (b[MAN_W-1:0] == '0);
    zero_a  = (s1_ea == '0);
    zero_b  = (s1_eb == '0);

    s1_a_big = {s1_ea, s1_fa} >= {s1_eb, s1_fb};
    if (s1_a_big) begin
      sign1_d = s1_sa;
      exp1_d  = s1_ea;
      mbig1_d = s1_ma;
      s1_msml = s1_mb;
      s1_diff = s1_ea - s1_eb;
    end else begin
      sign1_d = s1_sb;
      exp1_d  = s1_eb;
      mbig1_d = s1_mb;
      s1_msml = s1_ma;
      s1_diff = s1_eb - s1_ea;
    end

    // Bits pushed below the sticky position are not lost: they fold into sticky.
    s1_sh   = (s1_diff > SH_MAX) ? SH_MAX : s1_diff;
    s1_mask = ~({MW{1'b1}} << s1_sh);
    msml1_d = (s1_msml >> s1_sh) | MW'(|(s1_msml & s1_mask));
    sub1_d  = s1_sa ^ s1_sb;
    v1_d    = in_valid;

    spec1_d = 1'b1;
    inv1_d  = 1'b0;
    sw1_d   = '0;
    if (nan_a || nan_b || (inf_a && inf_b && (s1_sa != s1_sb))) begin
      sw1_d  = QNAN;
      inv1_d = 1'b1;
    end else if (inf_a) begin
      sw1_d = {s1_sa, EXP_ONES, {MAN_W{1'b0}}};
    end else if (inf_b) begin
      sw1_d = {s1_sb, EXP_ONES, {MAN_W{1'b0}}};
    end else if (zero_a && zero_b) begin
      sw1_d = {s1_sa & s1_sb, {(W-1){1'b0}}};
    end else begin
      spec1_d = 1'b0;
    end
  end

  // NOTE: state uses non-blocking assignments so each stage captures its neighbour's pre-edge value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      sign1_q <= 1'b0;
      sub1_q  <= 1'b0;
      spec1_q <= 1'b0;
      inv1_q  <= 1'b0;
      exp1_q  <= '0;
      mbig1_q <= '0;
      msml1_q <= '0;
      sw1_q   <= '0;
    end else if (adv) begin
      v1_q    <= v1_d;
      sign1_q <= sign1_d;
      sub1_q  <= sub1_d;
      spec1_q <= spec1_d;
      inv1_q  <= inv1_d;
      exp1_q  <= exp1_d;
      mbig1_q <= mbig1_d;
      msml1_q <= msml1_d;
      sw1_q   <= sw1_d;
    end
  end

  // ---------------- S2: add / subtract and leading-zero count ----------------
  logic             v2_d, v2_q, sign2_d, sign2_q, spec2_d, spec2_q, inv2_d, inv2_q;
  logic [EXP_W-1:0] exp2_d, exp2_q;
  logic [SW-1:0]    res2_d, res2_q;
  logic [LZW-1:0]   lzc2_d, lzc2_q;
  logic [W-1:0]     sw2_d, sw2_q;

  always_comb begin
    v2_d    = v1_q;
    sign2_d = sign1_q;
    spec2_d = spec1_q;
    inv2_d  = inv1_q;
    exp2_d  = exp1_q;
    sw2_d   = sw1_q;
    // The big operand's magnitude is never below the aligned small one, so subtraction cannot go negative.
    res2_d  = sub1_q ? ({1'b0, mbig1_q} - {1'b0, msml1_q})
                     : ({1'b0, mbig1_q} + {1'b0, msml1_q});
    lzc2_d  = LZW'(MW);
    for (int i = 0; i < MW; i++) begin
      if (res2_d[i]) lzc2_d = LZW'(MW - 1 - i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q    <= 1'b0;
      sign2_q <= 1'b0;
      spec2_q <= 1'b0;
      inv2_q  <= 1'b0;
      exp2_q  <= '0;
      res2_q  <= '0;
      lzc2_q  <= '0;
      sw2_q   <= '0;
    end else if (adv) begin
      v2_q    <= v2_d;
      sign2_q <= sign2_d;
      spec2_q <= spec2_d;
      inv2_q  <= inv2_d;
      exp2_q  <= exp2_d;
      res2_q  <= res2_d;
      lzc2_q  <= lzc2_d;
      sw2_q   <= sw2_d;
    end
  end

  // ---------------- S3: normalise / round / pack ----------------
  logic signed [EW-1:0] s3_e;
  logic [MW-1:0]        s3_norm;
  logic                 s3_inc;
  logic [MAN_W+1:0]     s3_mr;
  logic [MAN_W-1:0]     s3_frac;

  logic         v3_d, v3_q, overflow_d, overflow_q, underflow_d, underflow_q, invalid_d, invalid_q;
  logic [W-1:0] sum_d, sum_q;

  always_comb begin
    s3_e = $signed({2'b00, exp2_q});
    if (res2_q[SW-1]) begin
      s3_norm = {res2_q[SW-1:2], res2_q[1] | res2_q[0]};
      s3_e    = s3_e + ONE_S;
    end else begin
      s3_norm = res2_q[MW-1:0] << lzc2_q;
      s3_e    = s3_e - $signed({{(EW-LZW){1'b0}}, lzc2_q});
    end

    s3_inc = s3_norm[2] & (s3_norm[1] | s3_norm[0] | s3_norm[3]);
    s3_mr  = {1'b0, s3_norm[MW-1:3]} + (MAN_W+2)'(s3_inc);
    if (s3_mr[MAN_W+1]) begin
      s3_frac = '0;
      s3_e    = s3_e + ONE_S;
    end else begin
      s3_frac = s3_mr[MAN_W-1:0];
    end

    sum_d       = '0;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    invalid_d   = 1'b0;
    if (spec2_q) begin
      sum_d     = sw2_q;
      invalid_d = inv2_q;
    end else if (res2_q == '0) begin
      sum_d = '0;
    end else if (s3_e >= EXP_INF) begin
      sum_d      = {sign2_q, EXP_ONES, {MAN_W{1'b0}}};
      overflow_d = 1'b1;
    end else if (s3_e <= ZERO_S) begin
      sum_d       = {sign2_q, {(W-1){1'b0}}};
      underflow_d = 1'b1;
    end else begin
      sum_d = {sign2_q, s3_e[EXP_W-1:0], s3_frac};
    end

    // Flags never appear on a bubble.
    overflow_d  = overflow_d  & v2_q;
    underflow_d = underflow_d & v2_q;
    invalid_d   = invalid_d   & v2_q;
    v3_d        = v2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3_q        <= 1'b0;
      sum_q       <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      invalid_q   <= 1'b0;
    end else if (adv) begin
      v3_q        <= v3_d;
      sum_q       <= sum_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      invalid_q   <= invalid_d;
    end
  end

  assign out_valid = v3_q;
  assign sum       = sum_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign invalid   = invalid_q;

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Bench for fp_addsub_pipe: directed vectors, an exact-arithmetic reference model with a
// scoreboard checked every cycle, plus backpressure and mid-flight reset scenarios.
module tb_fp_addsub_pipe;
  localparam int NV = 19;

  typedef struct packed {
    logic [31:0] sum;
    logic        ovf;
    logic        unf;
    logic        inv;
  } res_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [31:0] sum;
    logic [2:0]  flg;   // {overflow, underflow, invalid}
  } vec_t;

  logic        clk, rst_n, in_valid, in_ready, op, out_valid, out_ready;
  logic [31:0] a, b, sum;
  logic        overflow, underflow, invalid;

  int n_checks = 0;
  int n_fail   = 0;

  vec_t vecs [NV];
  res_t exp_q [$];
  res_t got_e;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_sum;
  logic [2:0]  prev_flg;

  fp_addsub_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .overflow  (overflow),
    .underflow (underflow),
    .invalid   (invalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Exact reference: both operands become integers in units of the smallest normal ulp,
  // are summed exactly, then rounded to 24 significant bits with ties to even.
  function automatic res_t model(input logic [31:0] x, input logic [31:0] y, input logic o);
    res_t r;
    logic sx, sy, sr;
    int ex, ey, p, e, sh;
    logic [22:0] fx, fy;
    logic [299:0] vx, vy, mag, q, rem, half;
    r  = '0;
    sx = x[31];      ex = int'(x[30:23]); fx = x[22:0];
    sy = y[31] ^ o;  ey = int'(y[30:23]); fy = y[22:0];
    if ((ex == 255 && fx != 0) || (ey == 255 && fy != 0) || (ex == 255 && ey == 255 && sx != sy)) begin
      r.sum = 32'h7FC00000;
      r.inv = 1'b1;
      return r;
    end
    if (ex == 255) begin r.sum = {sx, 8'hFF, 23'h0}; return r; end
    if (ey == 255) begin r.sum = {sy, 8'hFF, 23'h0}; return r; end
    if (ex == 0 && ey == 0) begin r.sum = {sx & sy, 31'h0}; return r; end
    vx = (ex == 0) ? '0 : (300'({1'b1, fx}) << (ex - 1));
    vy = (ey == 0) ? '0 : (300'({1'b1, fy}) << (ey - 1));
    if (sx == sy)      begin mag = vx + vy; sr = sx; end
    else if (vx >= vy) begin mag = vx - vy; sr = sx; end
    else               begin mag = vy - vx; sr = sy; end
    if (mag == '0) return r;
    p = 0;
    for (int i = 0; i < 300; i++) if (mag[i]) p = i;
    e = p - 22;
    if (p > 23) begin
      sh   = p - 23;
      q    = mag >> sh;
      rem  = mag & ((300'd1 << sh) - 300'd1);
      half = 300'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 300'd1;
    end else begin
      q = mag << (23 - p);
    end
    if (q[24]) begin q = q >> 1; e = e + 1; end
    if (e >= 255) begin
      r.sum = {sr, 8'hFF, 23'h0};
      r.ovf = 1'b1;
    end else if (e <= 0) begin
      r.sum = {sr, 31'h0};
      r.unf = 1'b1;
    end else begin
      r.sum = {sr, 8'(e), q[22:0]};
    end
    return r;
  endfunction

  // Scoreboard and protocol checks, sampled mid-cycle when inputs and outputs are both stable.
  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready_vs_stall", in_ready, !(out_valid && !out_ready));
      if (!out_valid) check("idle_flags_zero", {overflow, underflow, invalid}, 3'b000);
      if (prev_stall) begin
        check("stall_valid_held", out_valid, 1'b1);
        check("stall_sum_held", sum, prev_sum);
        check("stall_flags_held", {overflow, underflow, invalid}, prev_flg);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_result: got %h, required no result", sum);
        end else begin
          got_e = exp_q.pop_front();
          check("result_sum", sum, got_e.sum);
          check("result_flags", {overflow, underflow, invalid}, {got_e.ovf, got_e.unf, got_e.inv});
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, op));
      prev_stall = out_valid && !out_ready;
      prev_sum   = sum;
      prev_flg   = {overflow, underflow, invalid};
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic offer(input int i);
    int t = 0;
    in_valid = 1'b1; a = vecs[i].a; b = vecs[i].b; op = vecs[i].op;
    #1;
    while (!in_ready && t < 50) begin cyc(); #1; t++; end
    check("offer_accepted", in_ready, 1'b1);
    cyc();
  endtask

  task automatic send_latency(input int i);
    out_ready = 1'b1;
    in_valid = 1'b1; a = vecs[i].a; b = vecs[i].b; op = vecs[i].op;
    #1;
    check("lat_in_ready", in_ready, 1'b1);
    cyc();
    in_valid = 1'b0;
    check("lat_cycle1_idle", out_valid, 1'b0);
    cyc();
    check("lat_cycle2_idle", out_valid, 1'b0);
    cyc();
    check("lat_cycle3_valid", out_valid, 1'b1);
    check("lat_sum", sum, vecs[i].sum);
    check("lat_flags", {overflow, underflow, invalid}, vecs[i].flg);
  endtask

  task automatic drain();
    int t = 0;
    in_valid = 1'b0; out_ready = 1'b1;
    while (exp_q.size() != 0 && t < 50) begin cyc(); t++; end
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    res_t m;
    int idx, c;
    vecs = '{
      '{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3'b000},  // 1 + 2
      '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000},  // 1 - 1
      '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b000},  // tie to even
      '{32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 3'b000},  // above half
      '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b100},  // overflow
      '{32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 3'b010},  // underflow
      '{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 3'b001},  // inf - inf
      '{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b001},  // NaN in
      '{32'h40000000, 32'h3F800000, 1'b1, 32'h3F800000, 3'b000},  // 2 - 1
      '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000},  // -0 + -0
      '{32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 3'b000},  // +0 - +0
      '{32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 3'b000},  // -inf + 1
      '{32'h7F800000, 32'hFF800000, 1'b1, 32'h7F800000, 3'b000},  // inf - (-inf)
      '{32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 3'b000},  // subnormal flushed
      '{32'hC0400000, 32'h3F800000, 1'b0, 32'hC0000000, 3'b000},  // -3 + 1
      '{32'h3F800000, 32'hBF800000, 1'b0, 32'h00000000, 3'b000},  // cancellation
      '{32'h40490FDB, 32'h00000000, 1'b0, 32'h40490FDB, 3'b000},  // pi + 0
      '{32'h3F800000, 32'h33800000, 1'b1, 32'h3F7FFFFF, 3'b000},  // 1 - 2^-24
      '{32'h3F800000, 32'h33000000, 1'b1, 32'h3F800000, 3'b000}   // 1 - 2^-25 tie
    };

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; op = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_in_ready", in_ready, 1'b1);
    check("reset_sum", sum, 32'h0);
    check("reset_flags", {overflow, underflow, invalid}, 3'b000);

    for (int i = 0; i < NV; i++) begin
      m = model(vecs[i].a, vecs[i].b, vecs[i].op);
      check($sformatf("model_pin_%0d", i), {m.sum, m.ovf, m.unf, m.inv}, {vecs[i].sum, vecs[i].flg});
    end

    rst_n = 1'b1;
    send_latency(0);

    for (int i = 0; i < NV; i++) offer(i);
    drain();

    // Backpressure: eight beats back to back, consumer not ready during cycles 2..6.
    idx = 0;
    c = 0;
    while (idx < 8 && c < 100) begin
      out_ready = !(c >= 2 && c <= 6);
      in_valid = 1'b1; a = vecs[idx + 8].a; b = vecs[idx + 8].b; op = vecs[idx + 8].op;
      #1;
      if (in_ready) idx++;
      cyc();
      c++;
    end
    check("bp_all_accepted", idx, 8);
    drain();

    // Reset with three beats in flight.
    for (int i = 0; i < 3; i++) offer(i + 2);
    in_valid = 1'b0;
    check("pre_reset_valid", out_valid, 1'b1);
    check("pre_reset_inflight", exp_q.size(), 3);
    rst_n = 1'b0;
    #1;
    check("async_reset_valid", out_valid, 1'b0);
    check("async_reset_in_ready", in_ready, 1'b1);
    check("async_reset_sum", sum, 32'h0);
    check("async_reset_flags", {overflow, underflow, invalid}, 3'b000);
    exp_q.delete();
    cyc();
    cyc();
    rst_n = 1'b1;
    send_latency(3);
    repeat (6) cyc();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
